// File: rtl/thumb_shift_pkg.sv
// Shared types for the Thumb shift/immediate execute unit.
// Op codes, shift types and the default-width result bundle.
package thumb_shift_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        OP_SHIFT_REG  = 1'b0,
        OP_IMM_EXPAND = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        SRTYPE_LSL = 2'b00,
        SRTYPE_LSR = 2'b01,
        SRTYPE_ASR = 2'b10,
        SRTYPE_ROR = 2'b11
    } srtype_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic                  carry;
    } shift_res_t;

endpackage

// File: rtl/thumb_shift_core.sv
// Combinational shift / Thumb immediate expansion with ARM carry-out.
// Immediate expansion exists only when THUMB_SHIFT_IMM_EN is defined.
module thumb_shift_core
    import thumb_shift_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              op,
    input  logic [1:0]        srtype,
    input  logic [7:0]        amt,
    input  logic [DATA_W-1:0] operand,
    input  logic [11:0]       imm12,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    // One extra bit on the shifted-out side captures the carry for free
    logic [DATA_W:0]   lsl_ext;
    logic [DATA_W:0]   lsr_ext;
    logic [DATA_W:0]   asr_ext;
    logic [DATA_W-1:0] ror_val;
    logic [7:0]        rot;
    logic [DATA_W-1:0] sh_res;
    logic              sh_c;

    always_comb begin
        lsl_ext = {1'b0, operand} << amt;
        lsr_ext = {operand, 1'b0} >> amt;
        asr_ext = $signed({operand, 1'b0}) >>> amt;
        rot     = amt & 8'(DATA_W - 1);
        ror_val = DATA_W'({operand, operand} >> rot);
        sh_res  = operand;
        sh_c    = carry_in;
        unique case (srtype_e'(srtype))
            SRTYPE_LSL: if (amt != 8'd0) begin
                sh_res = lsl_ext[DATA_W-1:0];
                sh_c   = lsl_ext[DATA_W];
            end
            SRTYPE_LSR: if (amt != 8'd0) begin
                sh_res = lsr_ext[DATA_W:1];
                sh_c   = lsr_ext[0];
            end
            SRTYPE_ASR: if (amt != 8'd0) begin
                sh_res = asr_ext[DATA_W:1];
                sh_c   = asr_ext[0];
            end
            SRTYPE_ROR: if (amt == 8'd0) begin
                sh_res = {carry_in, operand[DATA_W-1:1]};
                sh_c   = operand[0];
            end else begin
                sh_res = ror_val;
                sh_c   = ror_val[DATA_W-1];
            end
            default: ;
        endcase
    end

`ifdef THUMB_SHIFT_IMM_EN
    logic [7:0]        b;
    logic [31:0]       pat;
    logic [DATA_W-1:0] rep;
    logic [DATA_W-1:0] imm_src;
    logic [DATA_W-1:0] imm_val;
    logic [7:0]        imm_rot;

    always_comb begin
        b = imm12[7:0];
        unique case (imm12[9:8])
            2'b00:   pat = {24'h0, b};
            2'b01:   pat = {8'h0, b, 8'h0, b};
            2'b10:   pat = {b, 8'h0, b, 8'h0};
            default: pat = {b, b, b, b};
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            rep[i] = pat[i % 32];
        end
        imm_src      = '0;
        imm_src[7:0] = {1'b1, imm12[6:0]};
        imm_rot      = {3'b000, imm12[11:7]} & 8'(DATA_W - 1);
        imm_val      = DATA_W'({imm_src, imm_src} >> imm_rot);
        result       = sh_res;
        carry        = sh_c;
        if (op_e'(op) == OP_IMM_EXPAND) begin
            if (imm12[11:10] == 2'b00) begin
                result = rep;
                carry  = carry_in;
            end else begin
                result = imm_val;
                carry  = imm_val[DATA_W-1];
            end
        end
    end
`else
    logic unused_imm;
    assign unused_imm = ^{op, imm12};
    assign result     = sh_res;
    assign carry      = sh_c;
`endif

endmodule

// File: rtl/thumb_shift_pipe.sv
// Elastic valid/ready pipeline around thumb_shift_core (ALU operand-B path).
// Define THUMB_SHIFT_IMM_EN to enable Thumb imm12 expansion.
module thumb_shift_pipe
    import thumb_shift_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [1:0]        in_srtype,
    input  logic [7:0]        in_amt,
    input  logic [DATA_W-1:0] in_operand,
    input  logic [11:0]       in_imm12,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
    } stage_t;

    logic [PIPE_STAGES-1:0] valid;
    logic [PIPE_STAGES-1:0] ready;
    stage_t                 data [PIPE_STAGES];
    stage_t                 comp;

    thumb_shift_core #(.DATA_W(DATA_W)) u_core (
        .op       (in_op),
        .srtype   (in_srtype),
        .amt      (in_amt),
        .operand  (in_operand),
        .imm12    (in_imm12),
        .carry_in (in_carry),
        .result   (comp.result),
        .carry    (comp.carry)
    );

    // Flattened ready chain: stage k may load if any stage at or after it has a bubble
    always_comb begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            logic r;
            r = out_ready;
            for (int j = k; j < PIPE_STAGES; j++) begin
                r = r | ~valid[j];
            end
            ready[k] = r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                valid[0] <= in_valid;
                if (in_valid) data[0] <= comp;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (ready[k]) begin
                    valid[k] <= valid[k-1];
                    if (valid[k-1]) data[k] <= data[k-1];
                end
            end
        end
    end

    assign in_ready   = ready[0];
    assign out_valid  = valid[PIPE_STAGES-1];
    assign out_result = data[PIPE_STAGES-1].result;
    assign out_carry  = data[PIPE_STAGES-1].carry;

endmodule

// File: tb/tb_thumb_shift_pipe.sv
// Self-checking bench for thumb_shift_pipe with a bit-serial reference model.
// Honours THUMB_SHIFT_IMM_EN the same way as the design.
module tb_thumb_shift_pipe;
    import thumb_shift_pkg::*;

    localparam int W  = 32;
    localparam int PS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [1:0]    in_srtype;
    logic [7:0]    in_amt;
    logic [W-1:0]  in_operand;
    logic [11:0]   in_imm12;
    logic          in_carry;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_carry;

    int            checks = 0;
    int            fails  = 0;
    shift_res_t    exp_q[$];

    always #5 clk = ~clk;

    thumb_shift_pipe #(.DATA_W(W), .PIPE_STAGES(PS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_srtype  (in_srtype),
        .in_amt     (in_amt),
        .in_operand (in_operand),
        .in_imm12   (in_imm12),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry)
    );

    // Reference: shifts applied one bit position at a time
    function automatic shift_res_t model(logic op, logic [1:0] sr, int n,
                                         logic [31:0] x, logic [11:0] imm,
                                         logic cin);
        shift_res_t  r;
        logic [31:0] v;
        logic [7:0]  b;
        logic        c;
        v = x;
        c = cin;
`ifdef THUMB_SHIFT_IMM_EN
        if (op) begin
            b = imm[7:0];
            if (imm[11:10] == 2'b00) begin
                case (imm[9:8])
                    2'd0:    v = {24'h0, b};
                    2'd1:    v = {8'h0, b, 8'h0, b};
                    2'd2:    v = {b, 8'h0, b, 8'h0};
                    default: v = {b, b, b, b};
                endcase
                c = cin;
            end else begin
                v = {24'h0, 1'b1, imm[6:0]};
                for (int i = 0; i < int'(imm[11:7]); i++) v = {v[0], v[31:1]};
                c = v[31];
            end
            r.result = v;
            r.carry  = c;
            return r;
        end
`else
        b = imm[7:0] ^ {7'h0, op};
`endif
        case (sr)
            2'd0: for (int i = 0; i < n; i++) begin
                c = v[31];
                v = {v[30:0], 1'b0};
            end
            2'd1: for (int i = 0; i < n; i++) begin
                c = v[0];
                v = {1'b0, v[31:1]};
            end
            2'd2: for (int i = 0; i < n; i++) begin
                c = v[0];
                v = {v[31], v[31:1]};
            end
            default: if (n == 0) begin
                v = {cin, x[31:1]};
                c = x[0];
            end else begin
                for (int i = 0; i < n % 32; i++) v = {v[0], v[31:1]};
                c = v[31];
            end
        endcase
        r.result = v;
        r.carry  = c;
        return r;
    endfunction

    function automatic shift_res_t cur_model();
        return model(in_op, in_srtype, int'(in_amt), in_operand, in_imm12, in_carry);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        in_op      = 1'($urandom_range(0, 1));
        in_srtype  = 2'($urandom_range(0, 3));
        in_operand = $urandom;
        in_imm12   = 12'($urandom);
        in_carry   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       in_amt = 8'd0;
            1:       in_amt = 8'd32;
            2:       in_amt = 8'd33;
            4:       in_amt = 8'($urandom);
            default: in_amt = 8'($urandom_range(1, 31));
        endcase
    endtask

    task automatic send_one(input logic op, input logic [1:0] sr,
                            input logic [7:0] amt, input logic [31:0] x,
                            input logic [11:0] imm, input logic cin,
                            output logic [31:0] r, output logic c,
                            output bit ok);
        bit acc;
        acc = 0;
        ok  = 0;
        r   = '0;
        c   = 1'b0;
        in_op = op; in_srtype = sr; in_amt = amt;
        in_operand = x; in_imm12 = imm; in_carry = cin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            #3;
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #3;
            if (out_valid) begin
                ok = 1;
                r  = out_result;
                c  = out_carry;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_op = 1'b0; in_srtype = 2'd0; in_amt = 8'd0;
        in_operand = '0; in_imm12 = '0; in_carry = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_result !== '0 || out_carry !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: got %h/%b expected 0/0", out_result, out_carry);
        end
        rst = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    typedef struct {
        logic        op;
        logic [1:0]  sr;
        logic [7:0]  amt;
        logic [31:0] x;
        logic [11:0] imm;
        logic        cin;
        logic [31:0] er;
        logic        ec;
        string       name;
    } vec_t;

    task automatic test_directed();
        vec_t        v[$];
        logic [31:0] r;
        logic        c;
        bit          ok;
        v.push_back('{1'b0, 2'd0, 8'd1,  32'h8000_0001, 12'h0, 1'b0, 32'h0000_0002, 1'b1, "lsl1"});
        v.push_back('{1'b0, 2'd0, 8'd32, 32'h8000_0001, 12'h0, 1'b0, 32'h0, 1'b1, "lsl32"});
        v.push_back('{1'b0, 2'd0, 8'd33, 32'h8000_0001, 12'h0, 1'b1, 32'h0, 1'b0, "lsl33"});
        v.push_back('{1'b0, 2'd2, 8'd40, 32'h8000_0000, 12'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, "asr40"});
        v.push_back('{1'b0, 2'd3, 8'd0,  32'h0000_0003, 12'h0, 1'b1, 32'h8000_0001, 1'b1, "rrx"});
        v.push_back('{1'b0, 2'd1, 8'd32, 32'h8000_0000, 12'h0, 1'b0, 32'h0, 1'b1, "lsr32"});
        v.push_back('{1'b0, 2'd3, 8'd32, 32'h8000_0001, 12'h0, 1'b0, 32'h8000_0001, 1'b1, "ror32"});
        v.push_back('{1'b0, 2'd1, 8'd0,  32'h0000_1234, 12'h0, 1'b1, 32'h0000_1234, 1'b1, "lsr0"});
        v.push_back('{1'b0, 2'd3, 8'd4,  32'h0000_0001, 12'h0, 1'b0, 32'h1000_0000, 1'b0, "ror4"});
`ifdef THUMB_SHIFT_IMM_EN
        v.push_back('{1'b1, 2'd0, 8'd0, 32'h0, 12'h3AB, 1'b0, 32'hABAB_ABAB, 1'b0, "imm3ab"});
        v.push_back('{1'b1, 2'd0, 8'd0, 32'h0, 12'h4FF, 1'b0, 32'h7F80_0000, 1'b0, "imm4ff"});
        v.push_back('{1'b1, 2'd3, 8'd7, 32'hFFFF, 12'h1AB, 1'b1, 32'h00AB_00AB, 1'b1, "imm1ab"});
`else
        v.push_back('{1'b1, 2'd0, 8'd4, 32'h1, 12'hFFF, 1'b0, 32'h0000_0010, 1'b0, "noimm"});
`endif
        foreach (v[i]) begin
            send_one(v[i].op, v[i].sr, v[i].amt, v[i].x, v[i].imm, v[i].cin, r, c, ok);
            checks++;
            if (!ok || r !== v[i].er || c !== v[i].ec) begin
                fails++;
                $display("FAIL %s: got %h/%b ok=%0d expected %h/%b",
                         v[i].name, r, c, ok, v[i].er, v[i].ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         got;
        int         first;
        shift_res_t e;
        got = 0;
        first = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            if (cyc < 16) begin
                rand_op();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #3;
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", cyc, in_ready);
                end
                exp_q.push_back(cur_model());
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                e = exp_q.pop_front();
                got++;
                checks++;
                if (out_result !== e.result || out_carry !== e.carry) begin
                    fails++;
                    $display("FAIL b2b_data: op %0d got %h/%b expected %h/%b",
                             got, out_result, out_carry, e.result, e.carry);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (first != PS) begin
            fails++;
            $display("FAIL b2b_latency: got %0d expected %0d", first, PS);
        end
        checks++;
        if (got != 16) begin
            fails++;
            $display("FAIL b2b_count: got %0d expected 16", got);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        int          acc_n;
        int          got;
        bit          full;
        logic [31:0] hr;
        logic        hc;
        shift_res_t  e;
        acc_n = 0; got = 0; full = 0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int c = 0; c < 10 && !full; c++) begin
            if (!in_valid) begin
                rand_op();
                in_valid = 1'b1;
            end
            #3;
            if (in_ready) begin
                exp_q.push_back(cur_model());
                acc_n++;
                tick();
                in_valid = 1'b0;
            end else begin
                full = 1;
            end
        end
        checks++;
        if (!full || acc_n != PS) begin
            fails++;
            $display("FAIL stall_fill: accepted %0d full=%0d expected %0d", acc_n, full, PS);
        end
        hr = out_result;
        hc = out_carry;
        for (int c = 0; c < 5; c++) begin
            tick();
            #3;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_result !== hr || out_carry !== hc) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d rdy=%b vld=%b got %h/%b expected %h/%b",
                         c, in_ready, out_valid, out_result, out_carry, hr, hc);
            end
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < acc_n; c++) begin
            #3;
            if (out_valid) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (out_result !== e.result || out_carry !== e.carry) begin
                    fails++;
                    $display("FAIL stall_drain: op %0d got %h/%b expected %h/%b",
                             got, out_result, out_carry, e.result, e.carry);
                end
            end
            tick();
        end
        checks++;
        if (got != acc_n) begin
            fails++;
            $display("FAIL stall_count: got %0d expected %0d", got, acc_n);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int          sent;
        int          got;
        bit          acc;
        bit          held;
        logic [31:0] hr;
        logic        hc;
        shift_res_t  e;
        sent = 0; got = 0; held = 0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 300; cyc++) begin
            acc = 0;
            if (!in_valid && sent < 300 && $urandom_range(0, 9) < 7) begin
                rand_op();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #3;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== hr || out_carry !== hc) begin
                    fails++;
                    $display("FAIL rand_stable: got %b %h/%b expected 1 %h/%b",
                             out_valid, out_result, out_carry, hr, hc);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_model());
                sent++;
                acc = 1;
            end
            held = out_valid && !out_ready;
            hr = out_result;
            hc = out_carry;
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: got %h/%b expected no result", out_result, out_carry);
                end else begin
                    e = exp_q.pop_front();
                    if (out_result !== e.result || out_carry !== e.carry) begin
                        fails++;
                        $display("FAIL rand_data: op %0d got %h/%b expected %h/%b",
                                 got, out_result, out_carry, e.result, e.carry);
                    end
                end
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 300 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_count: got %0d left %0d expected 300/0", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit stale;
        stale = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_carry !== 1'b0) begin
            fails++;
            $display("FAIL midreset_clear: got %b %h/%b expected 0 0/0",
                     out_valid, out_result, out_carry);
        end
        tick();
        rst = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            if (out_valid) stale = 1;
            tick();
            #3;
        end
        checks++;
        if (stale) begin
            fails++;
            $display("FAIL midreset_stale: got out_valid 1 expected 0");
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
